// File: rtl/pixart_i2c_seq.sv
// Pixart IR camera sequencer: drives i2c_master through the six-write init
// sequence, then loops forever on a pointer write (0x36) plus burst read.
module pixart_i2c_seq #(
  parameter logic [6:0] I2C_ADDR     = 7'h58,
  parameter int         GAP_CYCLES   = 100,
  parameter int         POLL_CYCLES  = 1000,
  parameter logic [2:0] READ_PACKETS = 3'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        i2c_ready,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic [15:0] i2c_data,
  output logic [2:0]  i2c_packets,
  output logic        i2c_rw,
  output logic        init_done,
  output logic        poll_strobe,
  output logic        busy
);

  localparam int MAX_CYCLES = (GAP_CYCLES > POLL_CYCLES) ? GAP_CYCLES : POLL_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  state_t           state, state_next;
  logic [2:0]       cmd_idx, cmd_idx_next;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_next;
  logic             start_next;
  logic [15:0]      data_next;
  logic [2:0]       packets_next;
  logic             rw_next;
  logic             init_done_next;
  logic             poll_strobe_next;
  logic             load;
  logic [2:0]       load_idx;

  function automatic logic [15:0] cmd_data(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_data = 16'h3001;
      3'd1:    cmd_data = 16'h3008;
      3'd2:    cmd_data = 16'h0690;
      3'd3:    cmd_data = 16'h08C0;
      3'd4:    cmd_data = 16'h1A40;
      3'd5:    cmd_data = 16'h3333;
      3'd6:    cmd_data = 16'h3600;
      default: cmd_data = 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] cmd_packets(input logic [2:0] idx);
    case (idx)
      3'd6:    cmd_packets = 3'd1;
      3'd7:    cmd_packets = READ_PACKETS;
      default: cmd_packets = 3'd2;
    endcase
  endfunction

  assign i2c_addr = I2C_ADDR;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_idx     <= 3'd0;
      gap_cnt     <= '0;
      i2c_start   <= 1'b0;
      i2c_data    <= 16'h0000;
      i2c_packets <= 3'd0;
      i2c_rw      <= 1'b0;
      init_done   <= 1'b0;
      poll_strobe <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_idx     <= cmd_idx_next;
      gap_cnt     <= gap_cnt_next;
      i2c_start   <= start_next;
      i2c_data    <= data_next;
      i2c_packets <= packets_next;
      i2c_rw      <= rw_next;
      init_done   <= init_done_next;
      poll_strobe <= poll_strobe_next;
    end
  end

  // Command fields are only reloaded together with a rising i2c_start
  always_comb begin
    state_next       = state;
    cmd_idx_next     = cmd_idx;
    gap_cnt_next     = gap_cnt;
    start_next       = i2c_start;
    data_next        = i2c_data;
    packets_next     = i2c_packets;
    rw_next          = i2c_rw;
    init_done_next   = init_done;
    poll_strobe_next = 1'b0;
    load             = 1'b0;
    load_idx         = cmd_idx;

    case (state)
      IDLE: begin
        cmd_idx_next = 3'd0;
        if (enable && i2c_ready) begin
          load       = 1'b1;
          load_idx   = 3'd0;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!i2c_ready) begin
          start_next = 1'b0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i2c_ready) begin
          if (cmd_idx == 3'd5) init_done_next = 1'b1;
          if (cmd_idx == 3'd7) poll_strobe_next = 1'b1;
          gap_cnt_next = (cmd_idx == 3'd7) ? POLL_LOAD : GAP_LOAD;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_next = gap_cnt - 1'b1;
        end else if (!enable) begin
          state_next     = IDLE;
          cmd_idx_next   = 3'd0;
          init_done_next = 1'b0;
        end else begin
          // After the read, fall back to the pointer write rather than re-init
          load       = 1'b1;
          load_idx   = (cmd_idx == 3'd7) ? 3'd6 : cmd_idx + 3'd1;
          state_next = WAIT_ACK;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      cmd_idx_next = load_idx;
      start_next   = 1'b1;
      data_next    = cmd_data(load_idx);
      packets_next = cmd_packets(load_idx);
      rw_next      = (load_idx == 3'd7);
    end
  end

endmodule
